// File: rtl/noc_params.sv
// Router-wide sizing constants and the port index type shared by the
// allocator stages.
package noc_params;

   localparam int PORT_NUM  = 5;
   localparam int VC_NUM    = 2;
   localparam int VC_SIZE   = $clog2(VC_NUM);
   localparam int PORT_SIZE = $clog2(PORT_NUM);

   typedef logic [PORT_SIZE-1:0] port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a registered priority pointer. The pointer moves
// just past the winner only when update_i is high and a grant was issued.
module round_robin_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] request_i,
   input  logic         update_i,
   output logic [N-1:0] grant_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic          found;

   // Linear scan from the pointer, wrapping modulo N; first requester wins.
   always_comb begin
      grant_o = '0;
      ptr_d   = ptr_q;
      found   = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!found && request_i[(int'(ptr_q) + k) % N]) begin
            found = 1'b1;
            grant_o[(int'(ptr_q) + k) % N] = 1'b1;
            ptr_d = PW'((int'(ptr_q) + k + 1) % N);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (update_i && found) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: one VC per input port, then one
// input port per output port, both chosen by round-robin arbiters.
module switch_allocator
   import noc_params::port_t;
#(
   parameter int PORT_NUM  = noc_params::PORT_NUM,
   parameter int VC_NUM    = noc_params::VC_NUM,
   parameter int VC_SIZE   = $clog2(VC_NUM),
   parameter int PORT_SIZE = $clog2(PORT_NUM)
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0]               request_i,
   input  port_t [PORT_NUM-1:0][VC_NUM-1:0]               out_port_i,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]  downstream_vc_i,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0]               on_off_i,
   output logic  [PORT_NUM-1:0]                           valid_sel_o,
   output logic  [PORT_NUM-1:0][VC_SIZE-1:0]              vc_sel_o,
   output logic  [PORT_NUM-1:0][PORT_SIZE-1:0]            input_sel_o,
   output logic  [PORT_NUM-1:0]                           output_valid_o
);

   logic  [PORT_NUM-1:0][VC_NUM-1:0]   eligible;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]   s1_grant;
   logic  [PORT_NUM-1:0][VC_SIZE-1:0]  win_vc;
   logic  [PORT_NUM-1:0]               has_win;
   port_t [PORT_NUM-1:0]               win_port;
   logic  [PORT_NUM-1:0][PORT_NUM-1:0] s2_req;
   logic  [PORT_NUM-1:0][PORT_NUM-1:0] s2_grant;

   genvar gi, gj;

   // Out-of-range port indices are treated as ineligible rather than aliased.
   generate
      for (gi = 0; gi < PORT_NUM; gi++) begin : g_elig
         for (gj = 0; gj < VC_NUM; gj++) begin : g_vc
            assign eligible[gi][gj] = !rst && request_i[gi][gj]
                                      && (int'(out_port_i[gi][gj]) < PORT_NUM)
                                      && on_off_i[out_port_i[gi][gj]][downstream_vc_i[gi][gj]];
         end
      end
   endgenerate

   generate
      for (gi = 0; gi < PORT_NUM; gi++) begin : g_stage1
         round_robin_arbiter #(.N(VC_NUM)) u_vc_arb (
            .clk       (clk),
            .rst       (rst),
            .request_i (eligible[gi]),
            .update_i  (valid_sel_o[gi]),
            .grant_o   (s1_grant[gi])
         );
      end
   endgenerate

   always_comb begin
      win_vc   = '0;
      has_win  = '0;
      win_port = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (s1_grant[i][v]) win_vc[i] = win_vc[i] | VC_SIZE'(v);
         end
         has_win[i]  = |s1_grant[i];
         win_port[i] = out_port_i[i][win_vc[i]];
      end
   end

   generate
      for (gi = 0; gi < PORT_NUM; gi++) begin : g_s2_req
         for (gj = 0; gj < PORT_NUM; gj++) begin : g_in
            assign s2_req[gi][gj] = has_win[gj] && (int'(win_port[gj]) == gi);
         end
      end
   endgenerate

   generate
      for (gi = 0; gi < PORT_NUM; gi++) begin : g_stage2
         round_robin_arbiter #(.N(PORT_NUM)) u_port_arb (
            .clk       (clk),
            .rst       (rst),
            .request_i (s2_req[gi]),
            .update_i  (output_valid_o[gi]),
            .grant_o   (s2_grant[gi])
         );
      end
   endgenerate

   // Grants are one-hot per output, so OR-ing indices converts to binary.
   always_comb begin
      output_valid_o = '0;
      input_sel_o    = '0;
      valid_sel_o    = '0;
      vc_sel_o       = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         output_valid_o[o] = |s2_grant[o];
         for (int i = 0; i < PORT_NUM; i++) begin
            if (s2_grant[o][i]) begin
               input_sel_o[o] = input_sel_o[o] | PORT_SIZE'(i);
               valid_sel_o[i] = 1'b1;
            end
         end
      end
      for (int i = 0; i < PORT_NUM; i++) begin
         if (valid_sel_o[i]) vc_sel_o[i] = win_vc[i];
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed stimulus for switch_allocator; a behavioural model checks every
// cycle and literal expectations pin the scenario outcomes.
module tb_switch_allocator;

   localparam int P = 5;
   localparam int V = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                       rst;
   logic [P-1:0][V-1:0]        request;
   logic [P-1:0][V-1:0][2:0]   out_port;
   logic [P-1:0][V-1:0][0:0]   dvc;
   logic [P-1:0][V-1:0]        on_off;
   logic [P-1:0]               valid_sel;
   logic [P-1:0][0:0]          vc_sel;
   logic [P-1:0][2:0]          input_sel;
   logic [P-1:0]               output_valid;

   int passed = 0;
   int total  = 0;
   int m_in_ptr[P];
   int m_out_ptr[P];
   bit done = 1'b0;

   switch_allocator dut (
      .clk             (clk),
      .rst             (rst),
      .request_i       (request),
      .out_port_i      (out_port),
      .downstream_vc_i (dvc),
      .on_off_i        (on_off),
      .valid_sel_o     (valid_sel),
      .vc_sel_o        (vc_sel),
      .input_sel_o     (input_sel),
      .output_valid_o  (output_valid)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Model: pick winners from the rules, compare, then advance pointers.
   always @(negedge clk) begin : cmp
      int w[P];
      int g[P];
      int v, op, i;
      logic [P-1:0]      e_vs, e_ov;
      logic [P-1:0][0:0] e_vc;
      logic [P-1:0][2:0] e_is;
      if (!done) begin
         e_vs = '0; e_ov = '0; e_vc = '0; e_is = '0;
         for (int p = 0; p < P; p++) begin
            w[p] = -1;
            g[p] = -1;
         end
         if (!rst) begin
            for (int p = 0; p < P; p++) begin
               for (int k = 0; k < V; k++) begin
                  v  = (m_in_ptr[p] + k) % V;
                  op = int'(out_port[p][v]);
                  if (w[p] < 0 && request[p][v] && op < P && on_off[op][dvc[p][v]]) w[p] = v;
               end
            end
            for (int o = 0; o < P; o++) begin
               for (int k = 0; k < P; k++) begin
                  i = (m_out_ptr[o] + k) % P;
                  if (g[o] < 0 && w[i] >= 0 && int'(out_port[i][w[i]]) == o) g[o] = i;
               end
               if (g[o] >= 0) begin
                  e_ov[o]    = 1'b1;
                  e_is[o]    = 3'(g[o]);
                  e_vs[g[o]] = 1'b1;
                  e_vc[g[o]] = 1'(w[g[o]]);
               end
            end
         end
         check("model valid_sel", int'(valid_sel), int'(e_vs));
         check("model vc_sel", int'(vc_sel), int'(e_vc));
         check("model input_sel", int'(input_sel), int'(e_is));
         check("model output_valid", int'(output_valid), int'(e_ov));
         if (rst) begin
            for (int p = 0; p < P; p++) begin
               m_in_ptr[p]  = 0;
               m_out_ptr[p] = 0;
            end
         end else begin
            for (int o = 0; o < P; o++) begin
               if (g[o] >= 0) begin
                  m_out_ptr[o]     = (g[o] + 1) % P;
                  m_in_ptr[g[o]]   = (w[g[o]] + 1) % V;
               end
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      request  = '0;
      out_port = '0;
      dvc      = '0;
      on_off   = '0;
   endtask

   task automatic do_reset();
      next_cycle();
      rst = 1'b1;
      clear_inputs();
      next_cycle();
      rst = 1'b0;
   endtask

   int cont_exp[5] = '{0, 2, 0, 2, 0};

   initial begin
      for (int p = 0; p < P; p++) begin
         m_in_ptr[p]  = 0;
         m_out_ptr[p] = 0;
      end
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset valid_sel", int'(valid_sel), 0);
      check("reset output_valid", int'(output_valid), 0);

      // Single request: input 1 VC 0 -> output 3, downstream VC 1
      next_cycle();
      rst = 1'b0;
      request[1][0] = 1'b1; out_port[1][0] = 3'd3; dvc[1][0] = 1'b1; on_off[3][1] = 1'b1;
      @(negedge clk);
      check("single valid_sel", int'(valid_sel), 5'b00010);
      check("single vc_sel1", int'(vc_sel[1]), 0);
      check("single input_sel3", int'(input_sel[3]), 1);
      check("single output_valid", int'(output_valid), 5'b01000);
      check("single input_sel all", int'(input_sel), 15'(1 << 9));

      // Output contention: inputs 0 and 2 both to output 4
      next_cycle();
      clear_inputs();
      request[0][0] = 1'b1; out_port[0][0] = 3'd4;
      request[2][0] = 1'b1; out_port[2][0] = 3'd4;
      on_off[4][0]  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) next_cycle();
         @(negedge clk);
         check("contention input_sel4", int'(input_sel[4]), cont_exp[c]);
         check("contention valid_sel", int'(valid_sel), (cont_exp[c] == 0) ? 1 : 4);
      end

      // Reset pulse mid-contention; without it input 2 would be next
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("rst pulse valid_sel", int'(valid_sel), 0);
      check("rst pulse input_sel", int'(input_sel), 0);
      check("rst pulse output_valid", int'(output_valid), 0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("post-rst input_sel4", int'(input_sel[4]), 0);
      check("post-rst valid_sel", int'(valid_sel), 1);

      // VC fairness at input 0
      do_reset();
      request[0] = 2'b11;
      out_port[0][0] = 3'd1; out_port[0][1] = 3'd2;
      on_off[1][0] = 1'b1; on_off[2][0] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) next_cycle();
         @(negedge clk);
         check("fairness vc_sel0", int'(vc_sel[0]), c % 2);
         check("fairness output_valid", int'(output_valid), (c % 2 == 0) ? 5'b00010 : 5'b00100);
      end

      // Backpressure: only the wrong downstream VC is on
      do_reset();
      request[3][1] = 1'b1; out_port[3][1] = 3'd0; dvc[3][1] = 1'b1;
      on_off[0][0] = 1'b1;
      for (int c = 0; c < 2; c++) begin
         if (c > 0) next_cycle();
         @(negedge clk);
         check("backpressure valid_sel", int'(valid_sel), 0);
         check("backpressure output_valid", int'(output_valid), 0);
      end
      next_cycle();
      on_off[0][1] = 1'b1;
      @(negedge clk);
      check("on rise valid_sel", int'(valid_sel), 5'b01000);
      check("on rise vc_sel3", int'(vc_sel[3]), 1);
      check("on rise input_sel0", int'(input_sel[0]), 3);
      check("on rise output_valid", int'(output_valid), 5'b00001);

      // Full parallelism: input i -> output (i+1) mod 5
      next_cycle();
      clear_inputs();
      for (int p = 0; p < P; p++) begin
         request[p][0]  = 1'b1;
         out_port[p][0] = 3'((p + 1) % P);
         on_off[p][0]   = 1'b1;
      end
      @(negedge clk);
      check("parallel valid_sel", int'(valid_sel), 5'h1f);
      check("parallel output_valid", int'(output_valid), 5'h1f);
      check("parallel input_sel0", int'(input_sel[0]), 4);
      check("parallel input_sel3", int'(input_sel[3]), 2);

      // Mixed contention: a stage-1 winner may lose stage 2
      next_cycle();
      clear_inputs();
      request[0] = 2'b11; out_port[0][0] = 3'd4; out_port[0][1] = 3'd4;
      request[1] = 2'b01; out_port[1][0] = 3'd4;
      request[2] = 2'b11; out_port[2][0] = 3'd1; out_port[2][1] = 3'd4;
      dvc[2][1] = 1'b1;
      on_off[4] = 2'b11; on_off[1][0] = 1'b1;
      repeat (8) next_cycle();

      next_cycle();
      done = 1'b1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
